can_frame_check: RTL and testbench

CAN_FRAME_CHECK -- requirements
Module: can_frame_check

---
 rtl/can_pkg.sv | 47 ++++
 rtl/can_crc15.sv | 35 +++
 rtl/can_frame_check.sv | 154 +++++++++++++++
 tb/tb_can_frame_check.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared constants for the CAN frame checker: frame field layout, CRC-15 parameters and FSM states.
// Bit positions index the destuffed frame vector, bit 0 = SOF, MSB-first.
package can_pkg;

  localparam int FRAME_LEN = 108;

  localparam int CRC_W = 15;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  localparam int SOF_POS     = 0;
  localparam int ID_POS      = 1;
  localparam int ID_W        = 11;
  localparam int RTR_POS     = 12;
  localparam int IDE_POS     = 13;
  localparam int R0_POS      = 14;
  localparam int DLC_POS     = 15;
  localparam int DLC_W       = 4;
  localparam int DATA_POS    = 19;
  localparam int DATA_W      = 64;
  localparam int CRC_POS     = 83;
  localparam int CRC_DEL_POS = 98;
  localparam int ACK_POS     = 99;
  localparam int ACK_DEL_POS = 100;
  localparam int EOF_POS     = 101;
  localparam int EOF_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] dlc_clip(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // Keeps the first nbytes data bytes (first byte lives in bits [63:56]).
  function automatic logic [DATA_W-1:0] data_keep(input logic [3:0] nbytes);
    logic [DATA_W-1:0] m;
    m = '1;
    for (int b = 0; b < 8; b++) begin
      if (b >= int'(nbytes)) m[63-8*b -: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 register: one bit folded in per enabled cycle, clear has priority over enable.
module can_crc15
  import can_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             fb;

  always_comb begin
    fb    = bit_i ^ crc_q[CRC_W-1];
    crc_d = {crc_q[CRC_W-2:0], 1'b0};
    if (fb) crc_d = crc_d ^ CRC_POLY;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_frame_check.sv
// Checks a destuffed CAN frame bit-serially (CRC-15 over SOF..DATA) and reports captured fields after 21+8*min(DLC,8) cycles.
// Frames arriving while busy are dropped and flag a sticky overrun. Define CAN_FORM_CHECK_EN to enable fixed-form checking.
module can_frame_check
  import can_pkg::*;
#(
  parameter int P_FRAME_BITS = FRAME_LEN
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Frame_DV,
  input  logic [0:P_FRAME_BITS-1] i_Frame,
  output logic                  o_Busy,
  output logic                  o_Frame_DV,
  output logic [10:0]           o_Id,
  output logic                  o_Rtr,
  output logic [3:0]            o_Dlc,
  output logic [63:0]           o_Data,
  output logic                  o_Crc_Err,
  output logic                  o_Form_Err,
  output logic                  o_Overrun
);

  localparam int SH_W = CRC_POS;  // SOF through end of DATA: the bits that can be CRC-covered

  state_t              state_q;
  logic [6:0]          cnt_q;
  logic [SH_W-1:0]     sh_q;

  logic [ID_W-1:0]     id_c_q;
  logic                rtr_c_q;
  logic [DLC_W-1:0]    dlc_c_q;
  logic [DATA_W-1:0]   data_c_q;
  logic [CRC_W-1:0]    crc_rx_q;

  logic                busy_q;
  logic                dv_q;
  logic [ID_W-1:0]     id_q;
  logic                rtr_q;
  logic [DLC_W-1:0]    dlc_q;
  logic [DATA_W-1:0]   data_q;
  logic                crc_err_q;
  logic                ovr_q;

  logic                accept;
  logic [3:0]          dlc_eff_d;
  logic [6:0]          cnt_d;
  logic [CRC_W-1:0]    crc_val;
  logic                unused_bits;

  assign accept    = (state_q == ST_IDLE) && i_Frame_DV;
  assign dlc_eff_d = dlc_clip(i_Frame[DLC_POS +: DLC_W]);
  assign cnt_d     = 7'(DATA_POS) + {dlc_eff_d, 3'b000};

  // IDE, r0, ACK slot and the like only matter to the form check, if at all.
  assign unused_bits = ^i_Frame;

  can_crc15 u_crc (
    .clk_i   (i_Clock),
    .rst_n_i (i_Reset_n),
    .clr_i   (accept),
    .en_i    (state_q == ST_RUN),
    .bit_i   (sh_q[SH_W-1]),
    .crc_o   (crc_val)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      id_c_q    <= '0;
      rtr_c_q   <= 1'b0;
      dlc_c_q   <= '0;
      data_c_q  <= '0;
      crc_rx_q  <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      id_q      <= '0;
      rtr_q     <= 1'b0;
      dlc_q     <= '0;
      data_q    <= '0;
      crc_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (i_Frame_DV && (state_q != ST_IDLE)) ovr_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (i_Frame_DV) begin
            sh_q     <= i_Frame[SOF_POS +: SH_W];
            cnt_q    <= cnt_d;
            id_c_q   <= i_Frame[ID_POS +: ID_W];
            rtr_c_q  <= i_Frame[RTR_POS];
            dlc_c_q  <= i_Frame[DLC_POS +: DLC_W];
            data_c_q <= i_Frame[DATA_POS +: DATA_W] & data_keep(dlc_eff_d);
            crc_rx_q <= i_Frame[CRC_POS +: CRC_W];
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sh_q  <= {sh_q[SH_W-2:0], 1'b0};
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_q <= ST_DONE;
        end
        ST_DONE: begin
          dv_q      <= 1'b1;
          id_q      <= id_c_q;
          rtr_q     <= rtr_c_q;
          dlc_q     <= dlc_c_q;
          data_q    <= data_c_q;
          crc_err_q <= (crc_val != crc_rx_q);
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CAN_FORM_CHECK_EN
  logic form_bad_d;
  logic form_c_q;
  logic form_err_q;

  assign form_bad_d = i_Frame[SOF_POS] | ~i_Frame[CRC_DEL_POS] | ~i_Frame[ACK_DEL_POS]
                    | ~(&i_Frame[EOF_POS +: EOF_W]);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      form_c_q   <= 1'b0;
      form_err_q <= 1'b0;
    end else begin
      if (accept) form_c_q <= form_bad_d;
      if (state_q == ST_DONE) form_err_q <= form_c_q;
    end
  end

  assign o_Form_Err = form_err_q;
`else
  assign o_Form_Err = 1'b0;
`endif

  assign o_Busy     = busy_q;
  assign o_Frame_DV = dv_q;
  assign o_Id       = id_q;
  assign o_Rtr      = rtr_q;
  assign o_Dlc      = dlc_q;
  assign o_Data     = data_q;
  assign o_Crc_Err  = crc_err_q;
  assign o_Overrun  = ovr_q;

endmodule

// File: tb/tb_can_frame_check.sv
// Scoreboard bench for can_frame_check: expected results are queued when a frame is driven and compared when o_Frame_DV fires.
module tb_can_frame_check;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_dv;
  logic [0:107] frame;
  logic         busy, out_dv, rtr, crc_err, form_err, overrun;
  logic [10:0]  id;
  logic [3:0]   dlc;
  logic [63:0]  data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        crc_err;
    logic        form_err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  can_frame_check #(.P_FRAME_BITS(108)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Frame_DV (frame_dv),
    .i_Frame    (frame),
    .o_Busy     (busy),
    .o_Frame_DV (out_dv),
    .o_Id       (id),
    .o_Rtr      (rtr),
    .o_Dlc      (dlc),
    .o_Data     (data),
    .o_Crc_Err  (crc_err),
    .o_Form_Err (form_err),
    .o_Overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [14:0] gold_crc(input logic [0:107] f, input int nbits);
    logic [14:0] r;
    logic        fb;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      fb = f[i] ^ r[14];
      r  = {r[13:0], 1'b0};
      if (fb) r = r ^ 15'h4599;
    end
    return r;
  endfunction

  // Drives one frame; when push is set the expected result joins the scoreboard.
  task automatic send(input logic [10:0] f_id, input logic f_rtr, input logic [3:0] f_dlc,
                      input logic [63:0] f_data, input logic [14:0] crc_flip,
                      input logic sof, input logic ack_del, input bit push);
    logic [0:107] f;
    logic [14:0]  c;
    logic [63:0]  keep;
    int           nb;
    exp_t         e;
    f = '0;
    f[0] = sof;
    for (int i = 0; i < 11; i++) f[1+i] = f_id[10-i];
    f[12] = f_rtr;
    for (int i = 0; i < 4; i++) f[15+i] = f_dlc[3-i];
    for (int i = 0; i < 64; i++) f[19+i] = f_data[63-i];
    nb = (f_dlc > 4'd8) ? 8 : int'(f_dlc);
    c  = gold_crc(f, 19 + 8*nb) ^ crc_flip;
    for (int i = 0; i < 15; i++) f[83+i] = c[14-i];
    f[98]  = 1'b1;
    f[100] = ack_del;
    for (int i = 0; i < 7; i++) f[101+i] = 1'b1;
    keep = '0;
    for (int b = 0; b < nb; b++) keep[63-8*b -: 8] = 8'hFF;

    @(posedge clk); #1;
    frame    = f;
    frame_dv = 1'b1;
    e.due      = cyc + 19 + 8*nb + 2;
    e.id       = f_id;
    e.rtr      = f_rtr;
    e.dlc      = f_dlc;
    e.data     = f_data & keep;
    e.crc_err  = (crc_flip != 15'h0);
`ifdef CAN_FORM_CHECK_EN
    e.form_err = sof | ~ack_del;
`else
    e.form_err = 1'b0;
`endif
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    frame_dv = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) chk("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (out_dv) begin
      if (sb.size() == 0) begin
        chk("unexpected_dv", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency",  64'(cyc),     64'(e.due));
        chk("id",       64'(id),      64'(e.id));
        chk("rtr",      64'(rtr),     64'(e.rtr));
        chk("dlc",      64'(dlc),     64'(e.dlc));
        chk("data",     data,         e.data);
        chk("crc_err",  64'(crc_err), 64'(e.crc_err));
        chk("form_err", 64'(form_err),64'(e.form_err));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    frame_dv = 1'b0;
    frame    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_dv",      64'(out_dv),  64'd0);
    chk("rst_id",      64'(id),      64'd0);
    chk("rst_data",    data,         64'd0);
    chk("rst_crc_err", 64'(crc_err), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // All-zero frame, then the same with a corrupted CRC field.
    send(11'h000, 1'b0, 4'd0, 64'h0, 15'h0000, 1'b0, 1'b1, 1);
    wait_idle();
    send(11'h000, 1'b0, 4'd0, 64'h0, 15'h0001, 1'b0, 1'b1, 1);
    wait_idle();

    // Full 8-byte frame, busy during processing, results held afterwards.
    send(11'h7FF, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h0, 1'b0, 1'b1, 1);
    repeat (3) @(negedge clk);
    chk("busy_run", 64'(busy), 64'd1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("hold_id",   64'(id), 64'h7FF);
    chk("hold_data", data,    64'h0123456789ABCDEF);

    // DLC above 8 clips to 8; short DLC masks trailing bytes; RTR captured.
    send(11'h123, 1'b1, 4'd12, 64'hFEDCBA9876543210, 15'h0, 1'b0, 1'b1, 1);
    wait_idle();
    send(11'h456, 1'b0, 4'd3, 64'hAABBCCDDEEFF1122, 15'h0, 1'b0, 1'b1, 1);
    wait_idle();

    // Form violations: ACK delimiter low, SOF high.
    send(11'h055, 1'b0, 4'd1, 64'h5A00000000000000, 15'h0, 1'b0, 1'b0, 1);
    wait_idle();
    send(11'h2AA, 1'b0, 4'd2, 64'hC3C3000000000000, 15'h0, 1'b1, 1'b1, 1);
    wait_idle();

    for (int k = 0; k < 6; k++) begin
      logic [14:0] flip;
      flip = ($urandom_range(0, 1) == 1) ? 15'(32'd1 << $urandom_range(0, 14)) : 15'h0;
      send(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, flip, 1'b0, 1'b1, 1);
      wait_idle();
    end

    chk("overrun_clear", 64'(overrun), 64'd0);
    // Second frame arrives mid-check: dropped, overrun sticks.
    send(11'h3C5, 1'b0, 4'd8, 64'h1122334455667788, 15'h0, 1'b0, 1'b1, 1);
    repeat (8) @(posedge clk);
    send(11'h001, 1'b0, 4'd0, 64'h0, 15'h0, 1'b0, 1'b1, 0);
    wait_idle();
    repeat (30) @(negedge clk);
    chk("overrun_set", 64'(overrun), 64'd1);

    // Reset five cycles into RUN abandons the frame.
    send(11'h100, 1'b0, 4'd4, 64'hDEADBEEF00000000, 15'h0, 1'b0, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_busy",    64'(busy),    64'd0);
    chk("mrst_id",      64'(id),      64'd0);
    chk("mrst_dlc",     64'(dlc),     64'd0);
    chk("mrst_data",    data,         64'd0);
    chk("mrst_crc_err", 64'(crc_err), 64'd0);
    chk("mrst_overrun", 64'(overrun), 64'd0);
    repeat (100) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
